q_row_fetch: RTL and testbench
==============================

Q_ROW_FETCH -- requirements
Module: q_row_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one Q-value word.
REQ-002 SHALL have parameter ACTIONS, default 4: Q-values per state; power of two, at least 2.
REQ-003 SHALL have parameter STATE_WIDTH, default 4: state index width.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1 bit: row-fetch request.
REQ-007 SHALL have port i_state, input, STATE_WIDTH bits: state whose row is fetched.
REQ-008 SHALL have port o_ready, output, 1 bit: block idle, request accepted.
REQ-009 SHALL have port o_ram_rd_en, output, 1 bit: Q-table read strobe.
REQ-010 SHALL have port o_ram_addr, output, STATE_WIDTH+log2(ACTIONS) bits: read address {state, action}.
REQ-011 SHALL have port i_ram_rdata, input, DATA_WIDTH bits: RAM read data, valid one cycle after strobe.
REQ-012 SHALL have port o_data, output, DATA_WIDTH*ACTIONS bits: packed row, action k in bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-013 SHALL have port o_valid, output, 1 bit: one-cycle pulse, row complete; drives the max-tree i_valid directly.

Function
REQ-014 SHALL be a four-state FSM: IDLE, READ, WAIT, DONE.
REQ-015 SHALL drive o_ready=1 only in IDLE.
REQ-016 SHALL accept a request at a rising edge only when i_start=1 and o_ready=1, latch i_state, clear the action counter, and go to READ.
REQ-017 SHALL ignore i_start outside IDLE: no queueing, and the latched state stays unchanged.
REQ-018 In READ, SHALL assert o_ram_rd_en with o_ram_addr={latched state, counter}, counter counting 0..ACTIONS-1, one address per cycle, for exactly ACTIONS consecutive cycles.
REQ-019 SHALL go from READ to WAIT after the cycle that issues counter=ACTIONS-1; counter SHALL NOT wrap into a further read.
REQ-020 SHALL register o_ram_rd_en and o_ram_addr: both are outputs of flops.
REQ-021 SHALL capture i_ram_rdata into lane k of o_data at the edge one cycle after the read of action k is sampled, using a one-cycle-delayed strobe and index.
REQ-022 SHALL leave WAIT after one cycle, when the last lane is captured, and go to DONE.
REQ-023 In DONE, SHALL assert o_valid for exactly one cycle, then return to IDLE.
REQ-024 SHALL make o_valid rise in cycle ACTIONS+2 relative to acceptance cycle 0; o_ready SHALL rise again in cycle ACTIONS+3.
REQ-025 SHALL hold o_data stable from DONE until the first lane write of the next fetch.
REQ-026 SHALL deassert o_ram_rd_en in IDLE, WAIT and DONE; the o_ram_addr value is don't-care there but SHALL NOT change in those states.
REQ-027 SHALL accept i_start asserted in the same cycle o_ready rises, giving back-to-back fetches every ACTIONS+3 cycles.
REQ-028 SHALL decode any unreachable FSM encoding to IDLE.

Reset
REQ-029 On rst_n=0, at any time including mid-fetch, SHALL immediately set: state IDLE, counter 0, latched state 0, o_data 0, o_valid 0, o_ram_rd_en 0, o_ram_addr 0.
REQ-030 SHALL present o_ready=1 in the first cycle after reset release.
REQ-031 SHALL NOT produce o_valid for a fetch aborted by reset, and SHALL NOT capture late RAM data from it.

Structure
REQ-032 SHALL take DATA_WIDTH, ACTIONS, STATE_WIDTH and the derived action-index width from the shared params package also used by the max tree.
REQ-033 SHALL define the FSM state encoding as localparams inside the module.
REQ-034 SHALL be a single module with no sub-modules; the Q-table RAM is external.

Verification
REQ-035 Single fetch, ACTIONS=4, DATA_WIDTH=32, RAM model word(addr)=addr*3, i_start at cycle 0 with i_state=5 -> reads at 20,21,22,23 in cycles 1-4; o_valid only in cycle 6; o_data={69,66,63,60} (lane3..lane0).
REQ-036 i_start held high continuously with i_state=2 -> fetch every 7 cycles; o_ready is low from the cycle after acceptance through the o_valid cycle.
REQ-037 i_start pulsed in cycle 3 of a fetch with i_state=9 -> ignored; current row completes for the original state; no second o_valid.
REQ-038 rst_n low in cycle 3 of a fetch -> all outputs 0 at once; no o_valid after release; o_ready=1 in the first cycle after release.
REQ-039 Boundary state i_state=15 -> addresses 60..63, no wrap to 0; then i_state=0 -> addresses 0..3.
REQ-040 Connected to the max tree with row {7,-2,100,5} (signed) -> max tree outputs 100 with its own valid, ACTIONS_WIDTH cycles after o_valid.

Source files
------------

// File: rtl/q_row_fetch_pkg.sv
// Shared Q-learning datapath parameters, used by the row fetcher and the max tree.
package q_row_fetch_pkg;

    // Index width for n items; never below one bit so single-item cases stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ACTIONS       = 4;
    localparam int unsigned STATE_WIDTH   = 4;
    localparam int unsigned ACTIONS_WIDTH = idx_width(ACTIONS);

endpackage

// File: rtl/q_row_fetch.sv
// Fetches one Q-table row (ACTIONS words) for a state from an external 1-cycle-latency
// RAM and presents it packed, with a one-cycle valid pulse for the max tree.
module q_row_fetch
    import q_row_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = q_row_fetch_pkg::DATA_WIDTH,
    parameter int unsigned ACTIONS     = q_row_fetch_pkg::ACTIONS,
    parameter int unsigned STATE_WIDTH = q_row_fetch_pkg::STATE_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_start,
    input  logic [STATE_WIDTH-1:0]                      i_state,
    output logic                                        o_ready,
    output logic                                        o_ram_rd_en,
    output logic [STATE_WIDTH+idx_width(ACTIONS)-1:0]   o_ram_addr,
    input  logic [DATA_WIDTH-1:0]                       i_ram_rdata,
    output logic [DATA_WIDTH*ACTIONS-1:0]               o_data,
    output logic                                        o_valid
);

    localparam int unsigned ACT_W  = idx_width(ACTIONS);
    localparam int unsigned ADDR_W = STATE_WIDTH + ACT_W;
    localparam int unsigned ROW_W  = DATA_WIDTH * ACTIONS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ACT_W-1:0] LAST_IDX = ACT_W'(ACTIONS - 1);

    logic [1:0]             state_q,   state_d;
    logic [ACT_W-1:0]       cnt_q,     cnt_d;
    logic [STATE_WIDTH-1:0] st_q,      st_d;
    logic [ADDR_W-1:0]      addr_q,    addr_d;
    logic                   rd_en_q,   rd_en_d;
    logic                   rd_dly_q,  rd_dly_d;
    logic [ACT_W-1:0]       idx_dly_q, idx_dly_d;
    logic [ROW_W-1:0]       data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   ready_q,   ready_d;

    // Next-state, read sequencing and lane capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_d      = st_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        valid_d   = 1'b0;
        ready_d   = 1'b0;
        rd_dly_d  = rd_en_q;
        idx_dly_d = cnt_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (i_start && ready_q) begin
                    state_d = S_READ;
                    st_d    = i_state;
                    cnt_d   = '0;
                    rd_en_d = 1'b1;
                    addr_d  = {i_state, ACT_W'(0)};
                    ready_d = 1'b0;
                end
            end
            S_READ: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = S_WAIT;
                end else begin
                    cnt_d   = cnt_q + ACT_W'(1);
                    rd_en_d = 1'b1;
                    addr_d  = {st_q, cnt_q + ACT_W'(1)};
                end
            end
            S_WAIT: begin
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RAM data arrives the cycle after its strobe; the delayed index picks the lane.
        for (int k = 0; k < int'(ACTIONS); k++) begin
            if (rd_dly_q && (idx_dly_q == ACT_W'(k))) begin
                data_d[k*DATA_WIDTH +: DATA_WIDTH] = i_ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            st_q      <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_dly_q  <= 1'b0;
            idx_dly_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            rd_dly_q  <= rd_dly_d;
            idx_dly_q <= idx_dly_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_ram_rd_en = rd_en_q;
    assign o_ram_addr  = addr_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_q_row_fetch.sv
// Bench for q_row_fetch: RAM model plus a per-fetch schedule model (reads in cycles
// 1..A, valid in A+2, ready in A+3) checked cycle by cycle on the falling edge.
module tb_q_row_fetch;

    localparam int DW = 32;
    localparam int A  = 4;
    localparam int SW = 4;
    localparam int AW = SW + 2;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [SW-1:0]     i_state;
    logic              o_ready;
    logic              o_ram_rd_en;
    logic [AW-1:0]     o_ram_addr;
    logic [DW-1:0]     ram_rdata;
    logic [DW*A-1:0]   o_data;
    logic              o_valid;

    logic [DW-1:0]     mem [0:63];
    logic [AW-1:0]     last_addr;
    logic [DW*A-1:0]   last_row;
    int                n_pass;
    int                n_total;

    q_row_fetch #(
        .DATA_WIDTH (DW),
        .ACTIONS    (A),
        .STATE_WIDTH(SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_state    (i_state),
        .o_ready    (o_ready),
        .o_ram_rd_en(o_ram_rd_en),
        .o_ram_addr (o_ram_addr),
        .i_ram_rdata(ram_rdata),
        .o_data     (o_data),
        .o_valid    (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read Q-table: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (o_ram_rd_en) ram_rdata <= mem[o_ram_addr];
    end

    // One fetch of state s, entered at a falling edge in cycle 0; returns at cycle A+3.
    task automatic run_fetch(input int s, input bit hold, input int inj_cycle, input int inj_state);
        logic [DW*A-1:0] exp_row;
        logic [AW-1:0]   exp_addr;
        logic            exp_rd;
        for (int k = 0; k < A; k++) exp_row[k*DW +: DW] = mem[s*A + k];
        n_total++;
        if (o_ready !== 1'b1) $display("FAIL ready_c0 s=%0d got %0b exp 1", s, o_ready);
        else n_pass++;
        i_start = 1'b1;
        i_state = SW'(s);
        for (int c = 1; c <= A + 3; c++) begin
            @(negedge clk);
            exp_rd   = (c <= A);
            exp_addr = AW'(s*A + ((c <= A) ? c - 1 : A - 1));
            n_total++;
            if (o_ram_rd_en !== exp_rd)
                $display("FAIL rd_en s=%0d c=%0d got %0b exp %0b", s, c, o_ram_rd_en, exp_rd);
            else n_pass++;
            n_total++;
            if (o_ram_addr !== exp_addr)
                $display("FAIL addr s=%0d c=%0d got %0d exp %0d", s, c, o_ram_addr, exp_addr);
            else n_pass++;
            n_total++;
            if (o_valid !== (c == A + 2))
                $display("FAIL valid s=%0d c=%0d got %0b exp %0b", s, c, o_valid, (c == A + 2));
            else n_pass++;
            n_total++;
            if (o_ready !== (c == A + 3))
                $display("FAIL ready s=%0d c=%0d got %0b exp %0b", s, c, o_ready, (c == A + 3));
            else n_pass++;
            if (c >= A + 2) begin
                n_total++;
                if (o_data !== exp_row)
                    $display("FAIL row s=%0d c=%0d got %h exp %h", s, c, o_data, exp_row);
                else n_pass++;
            end
            if (c == 1 && !hold) i_start = 1'b0;
            if (c == inj_cycle) begin
                i_start = 1'b1;
                i_state = SW'(inj_state);
            end else if (inj_cycle != 0 && c == inj_cycle + 1) begin
                i_start = hold;
                i_state = SW'(s);
            end
        end
        last_addr = AW'(s*A + A - 1);
        last_row  = exp_row;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_total++;
            if (o_ready !== 1'b1 || o_ram_rd_en !== 1'b0 || o_valid !== 1'b0)
                $display("FAIL idle i=%0d got rdy=%0b rd=%0b vld=%0b exp 1/0/0",
                         i, o_ready, o_ram_rd_en, o_valid);
            else n_pass++;
            n_total++;
            if (o_ram_addr !== last_addr || o_data !== last_row)
                $display("FAIL idle_hold i=%0d got addr=%0d row=%h exp addr=%0d row=%h",
                         i, o_ram_addr, o_data, last_addr, last_row);
            else n_pass++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_total++;
        if (o_ready !== 1'b0 || o_ram_rd_en !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL %s_ctl got rdy=%0b rd=%0b vld=%0b exp 0/0/0",
                     tag, o_ready, o_ram_rd_en, o_valid);
        else n_pass++;
        n_total++;
        if (o_ram_addr !== '0 || o_data !== '0)
            $display("FAIL %s_dat got addr=%0d row=%h exp 0/0", tag, o_ram_addr, o_data);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_state = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n     = 1'b1;
        last_addr = '0;
        last_row  = '0;
        idle_cycles(1);
    endtask

    task automatic test_single();
        for (int a = 0; a < 64; a++) mem[a] = DW'(a * 3);
        run_fetch(5, 1'b0, 0, 0);
        n_total++;
        if (o_data !== {32'd69, 32'd66, 32'd63, 32'd60})
            $display("FAIL single_row got %h exp 00000045_00000042_0000003f_0000003c", o_data);
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_fetch(2, 1'b1, 0, 0);
        i_start = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_ignore_start();
        run_fetch(4, 1'b0, 3, 9);
        idle_cycles(A + 2);
    endtask

    task automatic test_reset_mid();
        n_total++;
        if (o_ready !== 1'b1) $display("FAIL rstmid_ready got %0b exp 1", o_ready);
        else n_pass++;
        i_start = 1'b1;
        i_state = SW'(6);
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n     = 1'b1;
        last_addr = '0;
        last_row  = '0;
        idle_cycles(A + 4);
    endtask

    task automatic test_boundary();
        run_fetch(15, 1'b0, 0, 0);
        run_fetch(0, 1'b0, 0, 0);
        idle_cycles(1);
    endtask

    task automatic test_random();
        for (int a = 0; a < 64; a++) mem[a] = $urandom;
        for (int i = 0; i < 8; i++) begin
            run_fetch(int'($urandom_range(0, 15)), 1'b0, 0, 0);
            idle_cycles(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_max_row();
        logic signed [DW-1:0] mx;
        logic signed [DW-1:0] lane;
        mem[7*A + 0] = 32'd5;
        mem[7*A + 1] = 32'd100;
        mem[7*A + 2] = 32'hFFFF_FFFE;
        mem[7*A + 3] = 32'd7;
        run_fetch(7, 1'b0, 0, 0);
        mx = o_data[DW-1:0];
        for (int k = 1; k < A; k++) begin
            lane = o_data[k*DW +: DW];
            if (lane > mx) mx = lane;
        end
        n_total++;
        if (mx !== 32'sd100) $display("FAIL row_max got %0d exp 100", mx);
        else n_pass++;
        idle_cycles(1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_boundary();
        test_random();
        test_max_row();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
